// File: rtl/prefetch_queue_pkg.sv
// Shared types and constants for the V30 instruction prefetch queue.
package prefetch_queue_pkg;

  localparam int PREFETCH_QUEUE_SIZE = 6;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_BUSY    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

  // Segment:offset to 20-bit physical word address (bit 0 forced low).
  function automatic logic [19:0] phys_word_addr(input logic [15:0] ps,
                                                 input logic [15:0] pc);
    logic [19:0] sum;
    sum = {ps, 4'b0000} + {4'b0000, pc};
    return sum & 20'hFFFFE;
  endfunction

endpackage

// File: rtl/prefetch_queue.sv
// V30 instruction prefetch queue: fetches code words from PS:PC and presents a
// byte-aligned window to the pre-decoder, which retires bytes from the head.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int QUEUE_SIZE = PREFETCH_QUEUE_SIZE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic                    flush,
  input  logic [15:0]             flush_ps,
  input  logic [15:0]             flush_pc,
  output logic                    fetch_req,
  output logic [19:0]             fetch_addr,
  input  logic                    fetch_ack,
  input  logic [15:0]             fetch_data,
  output logic [8*QUEUE_SIZE-1:0] q_bytes,
  output logic [2:0]              q_count,
  output logic [15:0]             head_pc,
  output logic [15:0]             head_ps,
  input  logic                    consume_valid,
  input  logic [3:0]              consume_size,
  output fetch_state_e            fetch_state
);

  // Bus handshake: fetch_req rises with fetch_addr and both hold steady until
  // the cycle fetch_ack is sampled high; the request drops on that same edge.
  // The bus cannot cancel, so a flush mid-request only marks the data as dead.

  fetch_state_e            state_q, state_d;
  logic [8*QUEUE_SIZE-1:0] q_q, q_d;
  logic [2:0]              count_q, count_d;
  logic [15:0]             ps_q, ps_d;
  logic [15:0]             head_pc_q, head_pc_d;
  logic [15:0]             fetch_pc_q, fetch_pc_d;
  logic [19:0]             addr_q, addr_d;

  logic [3:0]              shift;
  logic [3:0]              surv;
  logic [3:0]              free_bytes;
  logic [3:0]              need_bytes;
  logic [1:0]              n_app;
  logic [7:0]              app0;
  logic [8*QUEUE_SIZE-1:0] shifted;

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    count_d    = count_q;
    ps_d       = ps_q;
    head_pc_d  = head_pc_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    shift      = '0;
    surv       = '0;
    n_app      = '0;
    app0       = '0;
    shifted    = '0;
    free_bytes = 4'(QUEUE_SIZE) - {1'b0, count_q};
    need_bytes = fetch_pc_q[0] ? 4'd1 : 4'd2;

    if (flush) begin
      q_d        = '0;
      count_d    = '0;
      ps_d       = flush_ps;
      head_pc_d  = flush_pc;
      fetch_pc_d = flush_pc;
      if (state_q != FETCH_IDLE) begin
        state_d = fetch_ack ? FETCH_IDLE : FETCH_DISCARD;
      end
    end else begin
      if (consume_valid) begin
        shift     = consume_size;
        head_pc_d = head_pc_q + 16'(consume_size);
      end
      // An over-sized consume empties the queue rather than wrapping the count.
      surv    = ({1'b0, count_q} > shift) ? ({1'b0, count_q} - shift) : 4'd0;
      shifted = q_q >> {shift, 3'b000};

      if (state_q == FETCH_BUSY && fetch_ack) begin
        n_app      = fetch_pc_q[0] ? 2'd1 : 2'd2;
        app0       = fetch_pc_q[0] ? fetch_data[15:8] : fetch_data[7:0];
        fetch_pc_d = fetch_pc_q + (fetch_pc_q[0] ? 16'd1 : 16'd2);
      end

      for (int i = 0; i < QUEUE_SIZE; i++) begin
        q_d[8*i +: 8] = (4'(i) < surv) ? shifted[8*i +: 8] : 8'h00;
        if (n_app != 2'd0 && 4'(i) == surv) q_d[8*i +: 8] = app0;
        if (n_app == 2'd2 && 4'(i) == surv + 4'd1) q_d[8*i +: 8] = fetch_data[15:8];
      end
      count_d = 3'(surv + 4'(n_app));

      case (state_q)
        FETCH_IDLE: begin
          if (free_bytes >= need_bytes) begin
            state_d = FETCH_BUSY;
            addr_d  = phys_word_addr(ps_q, fetch_pc_q);
          end
        end
        FETCH_BUSY, FETCH_DISCARD: begin
          if (fetch_ack) state_d = FETCH_IDLE;
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH_IDLE;
      q_q        <= '0;
      count_q    <= '0;
      ps_q       <= 16'hFFFF;
      head_pc_q  <= 16'h0000;
      fetch_pc_q <= 16'h0000;
      addr_q     <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      q_q        <= q_d;
      count_q    <= count_d;
      ps_q       <= ps_d;
      head_pc_q  <= head_pc_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign fetch_req   = (state_q != FETCH_IDLE);
  assign fetch_addr  = addr_q;
  assign q_bytes     = q_q;
  assign q_count     = count_q;
  assign head_pc     = head_pc_q;
  assign head_ps     = ps_q;
  assign fetch_state = state_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: fill, flush, concurrent consume/ack,
// flush during a pending fetch, address wrap and clock-enable hold.
module tb_prefetch_queue;
  import prefetch_queue_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         ce;
  logic         flush;
  logic [15:0]  flush_ps;
  logic [15:0]  flush_pc;
  logic         fetch_req;
  logic [19:0]  fetch_addr;
  logic         fetch_ack;
  logic [15:0]  fetch_data;
  logic [47:0]  q_bytes;
  logic [2:0]   q_count;
  logic [15:0]  head_pc;
  logic [15:0]  head_ps;
  logic         consume_valid;
  logic [3:0]   consume_size;
  fetch_state_e fetch_state;

  int n_checks = 0;
  int n_fail   = 0;

  prefetch_queue #(.QUEUE_SIZE(6)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .flush(flush),
    .flush_ps(flush_ps), .flush_pc(flush_pc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .q_bytes(q_bytes), .q_count(q_count),
    .head_pc(head_pc), .head_ps(head_ps),
    .consume_valid(consume_valid), .consume_size(consume_size),
    .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && ce && consume_valid && !flush)
      assert (consume_size <= {1'b0, q_count})
        else $error("protocol violation: consume_size %0d > q_count %0d", consume_size, q_count);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output logic [19:0] a);
    int n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (fetch_req !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_req: fetch_req=%b required 1 within 20 cycles", fetch_req);
    end
    a = fetch_addr;
  endtask

  task automatic ack(input logic [15:0] d);
    fetch_ack  = 1'b1;
    fetch_data = d;
    step();
    fetch_ack  = 1'b0;
    fetch_data = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b1; flush = 1'b0; flush_ps = '0; flush_pc = '0;
    fetch_ack = 1'b0; fetch_data = '0; consume_valid = 1'b0; consume_size = '0;
    repeat (3) step();
    n_checks++;
    if (q_count !== 3'd0 || q_bytes !== 48'h0) begin
      n_fail++; $display("FAIL reset_queue: count=%0d bytes=%h required 0/0", q_count, q_bytes);
    end
    n_checks++;
    if (head_ps !== 16'hFFFF || head_pc !== 16'h0000) begin
      n_fail++; $display("FAIL reset_head: ps=%h pc=%h required FFFF/0000", head_ps, head_pc);
    end
    n_checks++;
    if (fetch_req !== 1'b0 || fetch_addr !== 20'h0) begin
      n_fail++; $display("FAIL reset_fetch: req=%b addr=%h required 0/00000", fetch_req, fetch_addr);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    logic [19:0] a;
    logic [19:0] exp_a [3];
    exp_a[0] = 20'hFFFF0; exp_a[1] = 20'hFFFF2; exp_a[2] = 20'hFFFF4;
    for (int k = 0; k < 3; k++) begin
      wait_req(a);
      n_checks++;
      if (a !== exp_a[k]) begin
        n_fail++; $display("FAIL fill_addr%0d: addr=%h required %h", k, a, exp_a[k]);
      end
      ack({a[7:0] + 8'd1, a[7:0]});
    end
    n_checks++;
    if (q_count !== 3'd6 || q_bytes !== 48'hF5F4F3F2F1F0) begin
      n_fail++; $display("FAIL fill_queue: count=%0d bytes=%h required 6/f5f4f3f2f1f0", q_count, q_bytes);
    end
    n_checks++;
    if (head_pc !== 16'h0000) begin
      n_fail++; $display("FAIL fill_head_pc: pc=%h required 0000", head_pc);
    end
    repeat (3) step();
    n_checks++;
    if (fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL fill_full_idle: req=%b required 0", fetch_req);
    end
  endtask

  task automatic test_flush_odd();
    logic [19:0] a;
    flush = 1'b1; flush_ps = 16'h1000; flush_pc = 16'h0003;
    step();
    flush = 1'b0;
    n_checks++;
    if (q_count !== 3'd0 || head_ps !== 16'h1000 || head_pc !== 16'h0003) begin
      n_fail++; $display("FAIL flush_state: count=%0d ps=%h pc=%h required 0/1000/0003", q_count, head_ps, head_pc);
    end
    wait_req(a);
    n_checks++;
    if (a !== 20'h10002) begin
      n_fail++; $display("FAIL flush_first_addr: addr=%h required 10002", a);
    end
    ack(16'h0302);
    n_checks++;
    if (q_count !== 3'd1 || q_bytes !== 48'h03) begin
      n_fail++; $display("FAIL odd_append: count=%0d bytes=%h required 1/03", q_count, q_bytes);
    end
    wait_req(a);
    n_checks++;
    if (a !== 20'h10004) begin
      n_fail++; $display("FAIL flush_next_addr: addr=%h required 10004", a);
    end
    ack(16'h0504);
    wait_req(a);
    n_checks++;
    if (a !== 20'h10006) begin
      n_fail++; $display("FAIL flush_third_addr: addr=%h required 10006", a);
    end
    ack(16'h0706);
    n_checks++;
    if (q_count !== 3'd5 || q_bytes !== 48'h0706050403) begin
      n_fail++; $display("FAIL five_bytes: count=%0d bytes=%h required 5/0706050403", q_count, q_bytes);
    end
    consume_valid = 1'b1; consume_size = 4'd1;
    step();
    consume_valid = 1'b0; consume_size = '0;
    n_checks++;
    if (q_count !== 3'd4 || head_pc !== 16'h0004 || fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL consume1: count=%0d pc=%h req=%b required 4/0004/0", q_count, head_pc, fetch_req);
    end
  endtask

  task automatic test_consume_and_ack();
    logic [19:0] a;
    wait_req(a);
    n_checks++;
    if (a !== 20'h10008) begin
      n_fail++; $display("FAIL cons_ack_addr: addr=%h required 10008", a);
    end
    consume_valid = 1'b1; consume_size = 4'd3;
    ack(16'h0908);
    consume_valid = 1'b0; consume_size = '0;
    n_checks++;
    if (q_count !== 3'd3 || q_bytes !== 48'h090807) begin
      n_fail++; $display("FAIL cons_ack_queue: count=%0d bytes=%h required 3/090807", q_count, q_bytes);
    end
    n_checks++;
    if (head_pc !== 16'h0007) begin
      n_fail++; $display("FAIL cons_ack_pc: pc=%h required 0007", head_pc);
    end
  endtask

  task automatic test_flush_busy();
    logic [19:0] a;
    wait_req(a);
    n_checks++;
    if (a !== 20'h1000A) begin
      n_fail++; $display("FAIL busy_addr: addr=%h required 1000a", a);
    end
    flush = 1'b1; flush_ps = 16'h2000; flush_pc = 16'h0010;
    step();
    flush = 1'b0;
    n_checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 20'h1000A || q_count !== 3'd0) begin
      n_fail++; $display("FAIL busy_hold: req=%b addr=%h count=%0d required 1/1000a/0", fetch_req, fetch_addr, q_count);
    end
    step();
    ack(16'hDEAD);
    n_checks++;
    if (fetch_req !== 1'b0 || q_count !== 3'd0 || q_bytes !== 48'h0) begin
      n_fail++; $display("FAIL discard: req=%b count=%0d bytes=%h required 0/0/0", fetch_req, q_count, q_bytes);
    end
    wait_req(a);
    n_checks++;
    if (a !== 20'h20010) begin
      n_fail++; $display("FAIL refetch_addr: addr=%h required 20010", a);
    end
    ack(16'h1110);
    n_checks++;
    if (q_count !== 3'd2 || q_bytes !== 48'h1110 || head_ps !== 16'h2000 || head_pc !== 16'h0010) begin
      n_fail++; $display("FAIL refetch_queue: count=%0d bytes=%h ps=%h pc=%h required 2/1110/2000/0010",
                         q_count, q_bytes, head_ps, head_pc);
    end
  endtask

  task automatic test_wrap();
    logic [19:0] a;
    flush = 1'b1; flush_ps = 16'h0000; flush_pc = 16'hFFFE;
    step();
    flush = 1'b0;
    wait_req(a);
    n_checks++;
    if (a !== 20'h0FFFE) begin
      n_fail++; $display("FAIL wrap_addr0: addr=%h required 0fffe", a);
    end
    ack(16'hFFFE);
    wait_req(a);
    n_checks++;
    if (a !== 20'h00000) begin
      n_fail++; $display("FAIL wrap_addr1: addr=%h required 00000", a);
    end
    ack(16'h0100);
    n_checks++;
    if (q_count !== 3'd4 || q_bytes !== 48'h0100FFFE) begin
      n_fail++; $display("FAIL wrap_queue: count=%0d bytes=%h required 4/0100fffe", q_count, q_bytes);
    end
    consume_valid = 1'b1; consume_size = 4'd1;
    step();
    n_checks++;
    if (head_pc !== 16'hFFFF || q_count !== 3'd3) begin
      n_fail++; $display("FAIL wrap_pc_ffff: pc=%h count=%0d required ffff/3", head_pc, q_count);
    end
    step();
    consume_valid = 1'b0; consume_size = '0;
    n_checks++;
    if (head_pc !== 16'h0000 || q_count !== 3'd2 || q_bytes !== 48'h0100) begin
      n_fail++; $display("FAIL wrap_pc_0000: pc=%h count=%0d bytes=%h required 0000/2/0100", head_pc, q_count, q_bytes);
    end
  endtask

  task automatic test_ce_hold();
    logic [19:0] a;
    ce = 1'b0;
    consume_valid = 1'b1; consume_size = 4'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== 20'h00002 || q_count !== 3'd2 || head_pc !== 16'h0000) begin
        n_fail++; $display("FAIL ce_hold%0d: req=%b addr=%h count=%0d pc=%h required 1/00002/2/0000",
                           k, fetch_req, fetch_addr, q_count, head_pc);
      end
    end
    consume_valid = 1'b0; consume_size = '0;
    ce = 1'b1;
    wait_req(a);
    ack(16'h0302);
    n_checks++;
    if (q_count !== 3'd4 || q_bytes !== 48'h03020100) begin
      n_fail++; $display("FAIL ce_resume: count=%0d bytes=%h required 4/03020100", q_count, q_bytes);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_flush_odd();
    test_consume_and_ack();
    test_flush_busy();
    test_wrap();
    test_ce_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch queue for the V30 core; sits directly upstream of the pre-decoder that fills `pre_decode_t`.
- Fetches code words from PS:PC over a simple request/acknowledge bus port and buffers up to QUEUE_SIZE bytes.
- Presents a byte-aligned window to the pre-decoder; the pre-decoder retires `pre_size` bytes per instruction.
- Refills from a new PS:PC when the execute stage flushes on a branch, call or return.

Parameters:
- QUEUE_SIZE, 6: byte capacity of the queue (V30 queue depth).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; all state holds when low
- flush  in  1  discard queue contents and restart fetching at flush_ps:flush_pc
- flush_ps  in  16  new code segment
- flush_pc  in  16  new program counter
- fetch_req  out  1  bus fetch request
- fetch_addr  out  20  physical word address of the fetch, bit 0 always 0
- fetch_ack  in  1  one-cycle acknowledge; fetch_data is valid in the same cycle
- fetch_data  in  16  fetched word, little-endian
- q_bytes  out  8*QUEUE_SIZE  queue contents; byte 0 (head) in bits [7:0]; bytes at index ≥ q_count read 0
- q_count  out  3  number of valid bytes
- head_pc  out  16  PC of byte 0
- head_ps  out  16  current code segment
- consume_valid  in  1  pre-decoder retires bytes this cycle
- consume_size  in  4  number of bytes retired (matches `pre_size`); must be ≤ q_count

Behaviour:
- Reset (asynchronous, reset_n low):
  - q_count = 0, q_bytes = 0
  - head_ps = fetch_ps = 16'hFFFF; head_pc = fetch_pc = 16'h0000
  - fetch_req = 0, fetch_addr = 0, discard flag = 0
  - Reset mid-fetch abandons the request; the bus owner also resets.
- Physical address: `fetch_addr = ({fetch_ps,4'b0} + fetch_pc) & 20'hFFFFE`, computed modulo 2^20.
- Fetch issue:
  - Condition: ce, fetch_req low, flush low, and free space (QUEUE_SIZE − q_count) ≥ 2. For an odd fetch_pc, free space ≥ 1 suffices.
  - When the condition holds, fetch_req rises on the next edge.
  - fetch_req and fetch_addr stay stable until the cycle fetch_ack is sampled high. fetch_req falls on that edge.
  - Earliest next issue is the following cycle (no back-to-back requests).
- Ack accept, discard flag clear:
  - Even fetch_pc: append fetch_data[7:0] then [15:8]; fetch_pc += 2.
  - Odd fetch_pc: append only fetch_data[15:8]; fetch_pc += 1.
  - fetch_pc wraps within 16 bits; fetch_ps is unchanged. PC FFFF is odd, so only one byte is fetched and the next fetch_pc is 0000.
- Consume: when consume_valid, shift the queue down by consume_size bytes and set head_pc += consume_size (16-bit wrap).
- Consume and ack in the same cycle: both apply. New q_count = q_count − consume_size + appended. Appended bytes land after the surviving bytes. The issue rule guarantees no overflow.
- Flush (highest priority; overrides consume and ack in the same cycle):
  - q_count := 0.
  - head_ps = fetch_ps := flush_ps; head_pc = fetch_pc := flush_pc.
  - If fetch_req is high and not acked this cycle: keep fetch_req/fetch_addr until ack (the bus cannot cancel), set the discard flag, and drop that ack's data. The discard flag clears on that ack.
  - New fetch issues at the earliest the cycle after fetch_req falls.
  - A flush while fetch_req is low allows issue on the next cycle.
- Illegal input: consume_size > q_count is a protocol violation. Bench asserts it; RTL clamps the count to 0.
- ce low freezes all registers; fetch_req is held.

Decomposition:
- Add to the types package:
  - `PREFETCH_QUEUE_SIZE` constant (6).
  - `fetch_state_e {FETCH_IDLE, FETCH_BUSY, FETCH_DISCARD}`.
- Single module; no sub-module needed. The byte shift/append network is a combinational block inside it.

Test Plan:
- Reset then ack every request with data = {addr[7:0]+1, addr[7:0]}:
  - first fetch_addr = 20'hFFFF0
  - queue fills to 6 bytes in 3 fetches, then fetch_req stays low
  - head_pc = 0000
- flush to PS=1000, PC=0003:
  - first fetch_addr = 20'h10002, one byte appended, q_count = 1
  - next fetch_addr = 20'h10004
- Consume 3 and ack (2 bytes) in the same cycle with q_count = 4:
  - q_count = 3
  - head_pc advances by 3
  - byte order preserved
- flush while fetch_req is high, ack 2 cycles later with data 16'hDEAD:
  - q_count stays 0
  - fetch_req falls on ack
  - next fetch targets the flush address
- fetch_pc = FFFE, PS = 0000:
  - fetches 0xFFFE then 0x00000
  - head_pc wraps FFFF→0000 after consume
- ce low for 5 cycles with ack pulses held off:
  - no state change
  - fetch_req and fetch_addr unchanged
